// File: rtl/hub75_bcm_driver_if.sv
// Line-buffer read port and HUB75 panel pins of the BCM row driver.
// master = driver side, slave = line buffer / panel side.
interface hub75_bcm_driver_if #(
  parameter int COLUMNS       = 64,
  parameter int ROW_BITS      = 5,
  parameter int COLOR_BITS    = 8,
  parameter int LINE_BUF_BITS = 1
);
  localparam int ADDR_W = LINE_BUF_BITS + $clog2(COLUMNS);

  logic [ADDR_W-1:0]       read_address;
  logic [6*COLOR_BITS-1:0] read_data;
  logic                    drive_r1;
  logic                    drive_g1;
  logic                    drive_b1;
  logic                    drive_r2;
  logic                    drive_g2;
  logic                    drive_b2;
  logic                    drive_clk;
  logic                    drive_lat;
  logic                    drive_oe;
  logic [ROW_BITS-1:0]     drive_abcde;

  modport master (
    output read_address,
    input  read_data,
    output drive_r1, drive_g1, drive_b1, drive_r2, drive_g2, drive_b2,
    output drive_clk, drive_lat, drive_oe, drive_abcde
  );

  modport slave (
    input  read_address,
    output read_data,
    input  drive_r1, drive_g1, drive_b1, drive_r2, drive_g2, drive_b2,
    input  drive_clk, drive_lat, drive_oe, drive_abcde
  );
endinterface

// File: rtl/hub75_bcm_driver.sv
// HUB75 binary-code-modulation row driver: shifts each bit plane of one row,
// latches it, and lights it for OE_BASE<<plane cycles between blanking guards.
module hub75_bcm_driver #(
  parameter int COLUMNS       = 64,
  parameter int ROW_BITS      = 5,
  parameter int COLOR_BITS    = 8,
  parameter int OE_BASE       = 4,
  parameter int BLANK         = 2,
  parameter int LINE_BUF_BITS = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [ROW_BITS-1:0] y,
  output logic                is_idle,
  output logic                row_done,
  hub75_bcm_driver_if.master  hub
);
  localparam int COL_W  = $clog2(COLUMNS);
  localparam int PL_W   = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int CNT_W  = $clog2((OE_BASE << (COLOR_BITS - 1)) + 2 * BLANK + 1);
  localparam int WORD_W = 6 * COLOR_BITS;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

  // Pick bit p out of each of the six packed colour fields {b2,g2,r2,b1,g1,r1}.
  function automatic logic [5:0] plane_bits(input logic [WORD_W-1:0] word,
                                            input logic [PL_W-1:0]   p);
    logic [5:0] b;
    b = '0;
    for (int ch = 0; ch < 6; ch++) b[ch] = word[ch * COLOR_BITS + int'(p)];
    return b;
  endfunction

  state_t              state_q;
  logic [COL_W-1:0]    col_q;
  logic                ph_q;
  logic [PL_W-1:0]     plane_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ROW_BITS-1:0] row_q;
  logic                row_done_q;

  logic [CNT_W-1:0] win;
  logic [CNT_W-1:0] disp_last;

  assign win       = CNT_W'(OE_BASE) << plane_q;
  assign disp_last = win + CNT_W'(2 * BLANK - 1);

  always_ff @(posedge clock) begin
    row_done_q <= 1'b0;
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      ph_q    <= 1'b0;
      plane_q <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= SHIFT;
          row_q   <= y;
          plane_q <= '0;
          col_q   <= '0;
          ph_q    <= 1'b0;
        end
        SHIFT: begin
          ph_q <= ~ph_q;
          if (ph_q) begin
            col_q <= col_q + COL_W'(1);
            if (col_q == COL_W'(COLUMNS - 1)) state_q <= LATCH;
          end
        end
        LATCH: begin
          state_q <= DISPLAY;
          cnt_q   <= '0;
        end
        DISPLAY: begin
          if (cnt_q == disp_last) begin
            cnt_q <= '0;
            if (plane_q == PL_W'(COLOR_BITS - 1)) begin
              state_q    <= IDLE;
              row_done_q <= 1'b1;
            end else begin
              plane_q <= plane_q + PL_W'(1);
              state_q <= SHIFT;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign is_idle          = (state_q == IDLE);
  assign row_done         = row_done_q;
  assign hub.read_address = {row_q[LINE_BUF_BITS-1:0], col_q};

  // Stage p0: pin intent decoded from the FSM, aligned with the address.
  logic shift_p0, clk_p0, lat_p0, oe_p0, abcde_en_p0;

  assign shift_p0    = (state_q == SHIFT);
  assign clk_p0      = shift_p0 && ph_q;
  assign lat_p0      = (state_q == LATCH);
  assign abcde_en_p0 = lat_p0 && (plane_q == '0);
  assign oe_p0       = !((state_q == DISPLAY) && (cnt_q >= CNT_W'(BLANK)) &&
                         (cnt_q < win + CNT_W'(BLANK)));

  // Stage p1: controls wait one cycle for the line-buffer read data.
  logic            shift_p1, clk_p1, lat_p1, oe_p1, abcde_en_p1;
  logic [PL_W-1:0] plane_p1;

  always_ff @(posedge clock) begin
    plane_p1 <= plane_q;
    if (reset) begin
      shift_p1    <= 1'b0;
      clk_p1      <= 1'b0;
      lat_p1      <= 1'b0;
      oe_p1       <= 1'b1;
      abcde_en_p1 <= 1'b0;
    end else begin
      shift_p1    <= shift_p0;
      clk_p1      <= clk_p0;
      lat_p1      <= lat_p0;
      oe_p1       <= oe_p0;
      abcde_en_p1 <= abcde_en_p0;
    end
  end

  // Stage p2: registered panel pins, every one lagging the FSM by two cycles.
  logic [5:0]          colour_q;
  logic                drive_clk_q, drive_lat_q, drive_oe_q;
  logic [ROW_BITS-1:0] drive_abcde_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      colour_q      <= '0;
      drive_clk_q   <= 1'b0;
      drive_lat_q   <= 1'b0;
      drive_oe_q    <= 1'b1;
      drive_abcde_q <= '0;
    end else begin
      drive_clk_q <= clk_p1;
      drive_lat_q <= lat_p1;
      drive_oe_q  <= oe_p1;
      if (abcde_en_p1) drive_abcde_q <= row_q;
      if (shift_p1) colour_q <= plane_bits(hub.read_data, plane_p1);
    end
  end

  assign hub.drive_r1    = colour_q[0];
  assign hub.drive_g1    = colour_q[1];
  assign hub.drive_b1    = colour_q[2];
  assign hub.drive_r2    = colour_q[3];
  assign hub.drive_g2    = colour_q[4];
  assign hub.drive_b2    = colour_q[5];
  assign hub.drive_clk   = drive_clk_q;
  assign hub.drive_lat   = drive_lat_q;
  assign hub.drive_oe    = drive_oe_q;
  assign hub.drive_abcde = drive_abcde_q;
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Bench for hub75_bcm_driver: per-row pin waveform compared cycle by cycle
// against a plane-by-plane model built from the BCM timing rules.
module tb_hub75_bcm_driver;
  localparam int COLUMNS    = 4;
  localparam int ROW_BITS   = 5;
  localparam int COLOR_BITS = 2;
  localparam int OE_BASE    = 2;
  localparam int BLANK      = 1;
  localparam int LBB        = 1;
  localparam int LAG        = 2;   // address -> 1-cycle read -> registered pins
  localparam int ROW_CYC    = COLOR_BITS * (2 * COLUMNS + 1 + 2 * BLANK) +
                              OE_BASE * ((1 << COLOR_BITS) - 1);
  localparam int TAIL       = 4;
  localparam int PLANE0_LEN = 2 * COLUMNS + 1 + 2 * BLANK + OE_BASE;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic [ROW_BITS-1:0] y     = '0;
  logic                is_idle;
  logic                row_done;

  hub75_bcm_driver_if #(.COLUMNS(COLUMNS), .ROW_BITS(ROW_BITS),
                        .COLOR_BITS(COLOR_BITS), .LINE_BUF_BITS(LBB)) hub ();

  hub75_bcm_driver #(.COLUMNS(COLUMNS), .ROW_BITS(ROW_BITS), .COLOR_BITS(COLOR_BITS),
                     .OE_BASE(OE_BASE), .BLANK(BLANK), .LINE_BUF_BITS(LBB)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .y        (y),
    .is_idle  (is_idle),
    .row_done (row_done),
    .hub      (hub)
  );

  initial forever #5 clock = ~clock;

  logic [6*COLOR_BITS-1:0] mem [(1 << LBB) * COLUMNS];
  always @(posedge clock) hub.read_data <= mem[hub.read_address];

  int n_checks = 0;
  int n_pass   = 0;
  logic [ROW_BITS-1:0] prev_abcde = '0;

  int         m_clk[$], m_lat[$], m_oe[$], m_addr[$], m_colv[$];
  logic [5:0] m_col[$];

  int obs_clk[64], obs_r1[64], obs_b2[64];
  int done_cycle, done_count, rises, lats, oe_low;

  function automatic void push_cycle(int c, int l, int o, int a, int cv, logic [5:0] col);
    m_clk.push_back(c); m_lat.push_back(l); m_oe.push_back(o);
    m_addr.push_back(a); m_colv.push_back(cv); m_col.push_back(col);
  endfunction

  // One row as the panel should see it: per plane, shift columns, latch, light.
  function automatic void build_model(input logic [ROW_BITS-1:0] yv);
    logic [6*COLOR_BITS-1:0] w;
    logic [5:0] b;
    int a;
    m_clk.delete(); m_lat.delete(); m_oe.delete();
    m_addr.delete(); m_colv.delete(); m_col.delete();
    for (int p = 0; p < COLOR_BITS; p++) begin
      for (int c = 0; c < COLUMNS; c++) begin
        a = (int'(yv) % (1 << LBB)) * COLUMNS + c;
        w = mem[a];
        for (int ch = 0; ch < 6; ch++) b[ch] = w[ch * COLOR_BITS + p];
        push_cycle(0, 0, 1, a, 1, b);
        push_cycle(1, 0, 1, a, 1, b);
      end
      push_cycle(0, 1, 1, -1, 0, 6'd0);
      for (int i = 0; i < BLANK; i++) push_cycle(0, 0, 1, -1, 0, 6'd0);
      for (int i = 0; i < (OE_BASE << p); i++) push_cycle(0, 0, 0, -1, 0, 6'd0);
      for (int i = 0; i < BLANK; i++) push_cycle(0, 0, 1, -1, 0, 6'd0);
    end
  endfunction

  task automatic fill_mem();
    foreach (mem[i]) mem[i] = (6*COLOR_BITS)'($urandom);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (is_idle !== 1'b1 && t < 100) begin
      @(negedge clock);
      t++;
    end
    n_checks++;
    if (is_idle !== 1'b1) $display("FAIL wait_idle: is_idle=%b required 1", is_idle);
    else n_pass++;
  endtask

  task automatic run_row(input logic [ROW_BITS-1:0] yv, input bit poke);
    int idx, ec, el, eo;
    logic [5:0] obs_col;
    logic [ROW_BITS-1:0] eab;
    logic prev_clk;
    build_model(yv);
    wait_idle();
    start = 1'b1;
    y = yv;
    done_cycle = -1; done_count = 0; rises = 0; lats = 0; oe_low = 0;
    prev_clk = 1'b0;
    for (int k = 0; k < ROW_CYC + TAIL; k++) begin
      @(negedge clock);
      idx = k - LAG;
      ec = 0; el = 0; eo = 1;
      if (idx >= 0 && idx < m_clk.size()) begin
        ec = m_clk[idx]; el = m_lat[idx]; eo = m_oe[idx];
      end
      eab = (idx >= 2 * COLUMNS) ? yv : prev_abcde;
      obs_col = {hub.drive_b2, hub.drive_g2, hub.drive_r2,
                 hub.drive_b1, hub.drive_g1, hub.drive_r1};
      obs_clk[k] = int'(hub.drive_clk);
      obs_r1[k]  = int'(hub.drive_r1);
      obs_b2[k]  = int'(hub.drive_b2);
      if (hub.drive_clk && !prev_clk) rises++;
      prev_clk = hub.drive_clk;
      if (hub.drive_lat) lats++;
      if (!hub.drive_oe) oe_low++;
      if (row_done) begin done_count++; if (done_cycle < 0) done_cycle = k; end

      n_checks++;
      if (hub.drive_clk !== ec[0]) $display("FAIL clk k=%0d: got %b required %0d", k, hub.drive_clk, ec);
      else n_pass++;
      n_checks++;
      if (hub.drive_lat !== el[0]) $display("FAIL lat k=%0d: got %b required %0d", k, hub.drive_lat, el);
      else n_pass++;
      n_checks++;
      if (hub.drive_oe !== eo[0]) $display("FAIL oe k=%0d: got %b required %0d", k, hub.drive_oe, eo);
      else n_pass++;
      n_checks++;
      if (hub.drive_abcde !== eab) $display("FAIL abcde k=%0d: got %0d required %0d", k, hub.drive_abcde, eab);
      else n_pass++;
      n_checks++;
      if (row_done !== (k == ROW_CYC)) $display("FAIL row_done k=%0d: got %b required %b", k, row_done, k == ROW_CYC);
      else n_pass++;
      n_checks++;
      if (is_idle !== (k >= ROW_CYC)) $display("FAIL is_idle k=%0d: got %b required %b", k, is_idle, k >= ROW_CYC);
      else n_pass++;
      if (idx >= 0 && idx < m_colv.size() && m_colv[idx] == 1) begin
        n_checks++;
        if (obs_col !== m_col[idx]) $display("FAIL colour k=%0d: got %b required %b", k, obs_col, m_col[idx]);
        else n_pass++;
      end
      if (k < m_addr.size() && m_addr[k] >= 0) begin
        n_checks++;
        if (int'(hub.read_address) != m_addr[k])
          $display("FAIL read_address k=%0d: got %0d required %0d", k, hub.read_address, m_addr[k]);
        else n_pass++;
      end
      start = poke && (k == 3 || k == 10 || k == ROW_CYC - 1);
      if (poke) y = ROW_BITS'($urandom);
    end
    start = 1'b0;
    prev_abcde = yv;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (hub.drive_oe !== 1'b1) $display("FAIL reset_oe: got %b required 1", hub.drive_oe); else n_pass++;
    n_checks++; if (hub.drive_lat !== 1'b0) $display("FAIL reset_lat: got %b required 0", hub.drive_lat); else n_pass++;
    n_checks++; if (hub.drive_clk !== 1'b0) $display("FAIL reset_clk: got %b required 0", hub.drive_clk); else n_pass++;
    n_checks++; if (is_idle !== 1'b1) $display("FAIL reset_idle: got %b required 1", is_idle); else n_pass++;
    n_checks++; if (row_done !== 1'b0) $display("FAIL reset_done: got %b required 0", row_done); else n_pass++;
    n_checks++; if (hub.drive_abcde !== '0) $display("FAIL reset_abcde: got %0d required 0", hub.drive_abcde); else n_pass++;
    n_checks++; if (hub.read_address !== '0) $display("FAIL reset_addr: got %0d required 0", hub.read_address); else n_pass++;
    n_checks++;
    if ({hub.drive_b2, hub.drive_g2, hub.drive_r2, hub.drive_b1, hub.drive_g1, hub.drive_r1} !== 6'd0)
      $display("FAIL reset_colour: got nonzero required 0");
    else n_pass++;
    reset = 1'b0;
    prev_abcde = '0;
  endtask

  task automatic test_full_row();
    fill_mem();
    run_row(5'd5, 1'b0);
    n_checks++; if (rises != COLUMNS * COLOR_BITS) $display("FAIL clk_rises: got %0d required %0d", rises, COLUMNS * COLOR_BITS); else n_pass++;
    n_checks++; if (lats != COLOR_BITS) $display("FAIL lat_pulses: got %0d required %0d", lats, COLOR_BITS); else n_pass++;
    n_checks++; if (oe_low != 6) $display("FAIL oe_low_cycles: got %0d required 6", oe_low); else n_pass++;
    n_checks++; if (done_cycle != 28) $display("FAIL row_latency: got %0d required 28", done_cycle); else n_pass++;
    n_checks++; if (done_count != 1) $display("FAIL row_done_count: got %0d required 1", done_count); else n_pass++;
    n_checks++; if (hub.drive_abcde !== 5'd5) $display("FAIL full_abcde: got %0d required 5", hub.drive_abcde); else n_pass++;
  endtask

  task automatic test_address();
    fill_mem();
    run_row(5'd4, 1'b0);
    n_checks++; if (done_count != 1) $display("FAIL addr_row_done_count: got %0d required 1", done_count); else n_pass++;
  endtask

  task automatic test_bitplane();
    logic [6*COLOR_BITS-1:0] w;
    int k0, k1;
    fill_mem();
    w = mem[4];
    w[1:0]   = 2'b10;
    w[11:10] = 2'b01;
    mem[4] = w;
    run_row(5'd5, 1'b0);
    k0 = LAG + 1;
    k1 = LAG + PLANE0_LEN + 1;
    n_checks++; if (obs_clk[k0] != 1) $display("FAIL bp0_clk: got %0d required 1", obs_clk[k0]); else n_pass++;
    n_checks++; if (obs_r1[k0] != 0) $display("FAIL bp0_r1: got %0d required 0", obs_r1[k0]); else n_pass++;
    n_checks++; if (obs_b2[k0] != 1) $display("FAIL bp0_b2: got %0d required 1", obs_b2[k0]); else n_pass++;
    n_checks++; if (obs_clk[k1] != 1) $display("FAIL bp1_clk: got %0d required 1", obs_clk[k1]); else n_pass++;
    n_checks++; if (obs_r1[k1] != 1) $display("FAIL bp1_r1: got %0d required 1", obs_r1[k1]); else n_pass++;
    n_checks++; if (obs_b2[k1] != 0) $display("FAIL bp1_b2: got %0d required 0", obs_b2[k1]); else n_pass++;
  endtask

  task automatic test_busy_start();
    fill_mem();
    run_row(ROW_BITS'($urandom), 1'b1);
    n_checks++; if (done_count != 1) $display("FAIL busy_done_count: got %0d required 1", done_count); else n_pass++;
    n_checks++; if (done_cycle != ROW_CYC) $display("FAIL busy_latency: got %0d required %0d", done_cycle, ROW_CYC); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      fill_mem();
      run_row(ROW_BITS'($urandom), r[0]);
    end
  endtask

  task automatic test_reset_mid();
    int t, dn;
    fill_mem();
    wait_idle();
    start = 1'b1;
    y = ROW_BITS'($urandom);
    @(negedge clock);
    start = 1'b0;
    t = 0;
    while (hub.drive_oe !== 1'b0 && t < 60) begin
      @(negedge clock);
      t++;
    end
    n_checks++; if (hub.drive_oe !== 1'b0) $display("FAIL mid_window: oe=%b required 0 within bound", hub.drive_oe); else n_pass++;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++; if (hub.drive_oe !== 1'b1) $display("FAIL mid_oe: got %b required 1", hub.drive_oe); else n_pass++;
    n_checks++; if (is_idle !== 1'b1) $display("FAIL mid_idle: got %b required 1", is_idle); else n_pass++;
    n_checks++; if (row_done !== 1'b0) $display("FAIL mid_done: got %b required 0", row_done); else n_pass++;
    n_checks++; if (hub.drive_abcde !== '0) $display("FAIL mid_abcde: got %0d required 0", hub.drive_abcde); else n_pass++;
    dn = 0;
    repeat (40) begin
      @(negedge clock);
      if (row_done) dn++;
    end
    n_checks++; if (dn != 0) $display("FAIL mid_no_done: got %0d pulses required 0", dn); else n_pass++;
    prev_abcde = '0;
    fill_mem();
    run_row(ROW_BITS'($urandom), 1'b0);
    n_checks++; if (done_count != 1) $display("FAIL mid_fresh_done: got %0d required 1", done_count); else n_pass++;
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_full_row();
    test_address();
    test_bitplane();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/hub75_bcm_driver.md
HUB75_BCM_DRIVER -- requirements
Module: hub75_bcm_driver

Interface
REQ-001 SHALL have parameter COLUMNS, default 64: pixels shifted per row, power of two, 4..256.
REQ-002 SHALL have parameter ROW_BITS, default 5: width of the row-select bus.
REQ-003 SHALL have parameter COLOR_BITS, default 8: bits per colour channel, equal to the number of BCM planes, 1..10.
REQ-004 SHALL have parameter OE_BASE, default 4: OE-active cycles for plane 0, 1..64.
REQ-005 SHALL have parameter BLANK, default 2: OE-inactive guard cycles before and after each plane's OE window, 1..15.
REQ-006 SHALL have parameter LINE_BUF_BITS, default 1: number of row LSBs used to select the line buffer.
REQ-007 SHALL use one clock; reset is synchronous and active-high.
REQ-008 SHALL have ports clock (in, 1, clock) and reset (in, 1, synchronous active-high reset).
REQ-009 SHALL have port start (in, 1): begin one row; sampled only while idle.
REQ-010 SHALL have port y (in, ROW_BITS): row to display, captured into row_q on start acceptance.
REQ-011 SHALL have port is_idle (out, 1): high while in state IDLE.
REQ-012 SHALL have port row_done (out, 1): one-cycle pulse when a row's last plane completes.
REQ-013 SHALL have port read_address (out, LINE_BUF_BITS+log2(COLUMNS)), driven as {row_q[LINE_BUF_BITS-1:0], col}.
REQ-014 SHALL have port read_data (in, 6*COLOR_BITS), packed {b2,g2,r2,b1,g1,r1}, with r1 in the LSBs; read data is valid 1 cycle after the address.
REQ-015 SHALL have outputs drive_r1, drive_g1, drive_b1, drive_r2, drive_g2, drive_b2, drive_clk, drive_lat and drive_oe (each 1 bit), plus drive_abcde (ROW_BITS); all are registered.

Function
REQ-016 SHALL implement states IDLE, SHIFT, LATCH, DISPLAY.
REQ-017 SHALL transition IDLE->SHIFT on start, capturing row_q=y and setting plane=0 and col=0.
- start is ignored in every other state.
REQ-018 SHALL remain in SHIFT for 2*COLUMNS cycles per plane, then enter LATCH.
- Each column occupies 2 output cycles, with data stable in both: drive_clk=0 in the first, 1 in the second.
- Column 0 is shifted first.
REQ-019 SHALL present, during SHIFT for plane p, bit p of each channel field of the word at address column c on drive_r1..drive_b2.
REQ-020 SHALL drive LATCH for exactly 1 cycle: drive_lat=1, drive_clk=0, drive_oe=1; then enter DISPLAY.
REQ-021 SHALL sequence DISPLAY for plane p as follows, then go to SHIFT with plane+1, or to IDLE after plane COLOR_BITS-1.
- BLANK cycles with drive_oe=1.
- Then OE_BASE<<p cycles with drive_oe=0.
- Then BLANK cycles with drive_oe=1.
REQ-022 SHALL update drive_abcde to row_q only during the plane-0 LATCH cycle, and hold it otherwise.
REQ-023 SHALL keep drive_oe=1 in every state and cycle other than the DISPLAY active window.
REQ-024 SHALL keep drive_lat=0 outside LATCH, and drive_clk=0 outside SHIFT clock-high cycles.
REQ-025 SHALL assert row_done for exactly one cycle, on the transition into IDLE from DISPLAY.
REQ-026 SHALL keep the output waveform lag relative to state fixed and identical for all outputs.
REQ-027 SHALL make a row take exactly COLOR_BITS*(2*COLUMNS+1+2*BLANK) + OE_BASE*(2^COLOR_BITS-1) cycles from start acceptance to row_done.
REQ-028 SHALL size the DISPLAY counter to hold OE_BASE<<(COLOR_BITS-1)+2*BLANK without overflow.
- col wraps at COLUMNS-1 only at SHIFT exit.

Reset
REQ-029 SHALL, in the cycle after reset is sampled high, put the block in IDLE with these output values:
- is_idle=1, row_done=0, drive_oe=1, drive_lat=0, drive_clk=0.
- drive_abcde=0, colour outputs 0, read_address=0.
REQ-030 SHALL, on reset asserted in any state, mid-row included, abort the row with no row_done.
- If reset and start are both high in the same cycle, reset wins.

Verification (COLUMNS=4, COLOR_BITS=2, OE_BASE=2, BLANK=1, LINE_BUF_BITS=1, ROW_BITS=5)
REQ-031 SHALL cover power-on reset: hold reset 3 cycles -> drive_oe=1, drive_lat=0, drive_clk=0, is_idle=1, drive_abcde=0.
REQ-032 SHALL cover a full row: start with y=5 -> per plane, 4 drive_clk rises, 1 lat pulse, and drive_oe low for 2 cycles (plane 0) then 4 cycles (plane 1).
- drive_abcde=5.
- row_done 28 cycles after acceptance.
REQ-033 SHALL cover address sequencing: y=5 -> read_address sweeps 4,5,6,7 in each plane; with y=4 -> 0..3.
REQ-034 SHALL cover bit-plane selection: column 0 r1 field=2'b10, b2 field=2'b01 -> at plane 0 rising clk r1=0, b2=1; at plane 1 r1=1, b2=0.
REQ-035 SHALL cover start while busy: pulse start during SHIFT and DISPLAY -> no restart, one row_done, total 28 cycles unchanged.
REQ-036 SHALL cover reset mid-operation: assert reset during a DISPLAY active window -> next cycle drive_oe=1 and is_idle=1, no row_done; a fresh start then completes normally.
